// File: rtl/rc4_key_search_pkg.sv
// rc4_key_search_pkg: shared state encoding and default sizing for the key-search dispatcher.
package rc4_key_search_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FOUND, EXHAUSTED} state_t;
  localparam int DEF_KEY_W = 24;
  localparam int DEF_KEY_LIMIT = 2**22;
endpackage

// File: rtl/rc4_key_search_slot.sv
// rc4_key_search_slot: busy flag and last launched key for one arcfour core.
module rc4_key_search_slot
  import rc4_key_search_pkg::*;
#(
  parameter int KEY_W = DEF_KEY_W
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             launch_i,
  input  logic             done_i,
  input  logic             clear_i,
  input  logic [KEY_W-1:0] key_i,
  output logic             busy_o,
  output logic [KEY_W-1:0] key_o
);
  logic             busy_q;
  logic [KEY_W-1:0] key_q;
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      busy_q <= 1'b0;
      key_q  <= '0;
    end else begin
      busy_q <= clear_i ? 1'b0 : launch_i ? 1'b1 : done_i ? 1'b0 : busy_q;
      if (launch_i && !clear_i) key_q <= key_i;
    end
  end
  assign busy_o = busy_q;
  assign key_o  = key_q;
endmodule

// File: rtl/rc4_key_search_ctrl.sv
// rc4_key_search_ctrl: hands candidate keys to idle arcfour cores and latches the first success.
module rc4_key_search_ctrl
  import rc4_key_search_pkg::*;
#(
  parameter int NUM_CORES = 2,
  parameter int KEY_W     = DEF_KEY_W,
  parameter int KEY_LIMIT = DEF_KEY_LIMIT,
  parameter int CNT_W     = $clog2(KEY_LIMIT + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       start_i,
  input  logic                       stop_i,
  output logic [NUM_CORES-1:0]       core_start_o,
  output logic [NUM_CORES*KEY_W-1:0] core_key_o,
  output logic                       core_abort_o,
  input  logic [NUM_CORES-1:0]       core_done_i,
  input  logic [NUM_CORES-1:0]       core_success_i,
  output logic                       busy_o,
  output logic                       found_o,
  output logic                       exhausted_o,
  output logic [KEY_W-1:0]           found_key_o,
  output logic [CNT_W-1:0]           keys_tried_o
);
  localparam int IDX_W = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(KEY_LIMIT);

  state_t                 state_q;
  logic [CNT_W-1:0]       next_key_q, keys_tried_q;
  logic [NUM_CORES-1:0]   core_start_q;
  logic                   core_abort_q, found_q, exhausted_q;
  logic [KEY_W-1:0]       found_key_q;

  logic [NUM_CORES-1:0]   slot_busy, acc, hits, launch_vec;
  logic [KEY_W-1:0]       slot_key [NUM_CORES];
  logic [IDX_W-1:0]       idle_idx, win_idx;
  logic                   idle_any, run, go, halt, succ, have_keys, launch_en, clear;
  logic [CNT_W-1:0]       done_cnt;
  logic [KEY_W-1:0]       launch_key;

  always_comb begin
    acc      = core_done_i & slot_busy;
    hits     = acc & core_success_i;
    idle_any = 1'b0;
    idle_idx = '0;
    win_idx  = '0;
    done_cnt = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (!slot_busy[i]) begin
        idle_any = 1'b1;
        idle_idx = IDX_W'(i);
      end
      if (hits[i]) win_idx = IDX_W'(i);
      done_cnt = done_cnt + CNT_W'(acc[i]);
    end
    run       = state_q == RUN;
    go        = !run && start_i && !stop_i;
    halt      = run && stop_i;
    succ      = run && !stop_i && |hits;
    have_keys = next_key_q != LIMIT;
    // Starting a search always lands on slot 0 because every slot is idle outside RUN.
    launch_en  = go || (run && !stop_i && !succ && have_keys && idle_any);
    launch_vec = NUM_CORES'(launch_en) << idle_idx;
    launch_key = go ? '0 : KEY_W'(next_key_q);
    clear      = halt || succ;
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_slot
    rc4_key_search_slot #(.KEY_W(KEY_W)) u_slot (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .launch_i (launch_vec[g]),
      .done_i   (acc[g]),
      .clear_i  (clear),
      .key_i    (launch_key),
      .busy_o   (slot_busy[g]),
      .key_o    (slot_key[g])
    );
    assign core_key_o[g*KEY_W +: KEY_W] = slot_key[g];
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      next_key_q   <= '0;
      keys_tried_q <= '0;
      core_start_q <= '0;
      core_abort_q <= 1'b0;
      found_q      <= 1'b0;
      exhausted_q  <= 1'b0;
      found_key_q  <= '0;
    end else begin
      core_start_q <= launch_vec;
      core_abort_q <= clear;
      if (launch_en) next_key_q <= go ? CNT_W'(1) : next_key_q + CNT_W'(1);
      if (go) begin
        state_q      <= RUN;
        keys_tried_q <= '0;
        found_q      <= 1'b0;
        exhausted_q  <= 1'b0;
        found_key_q  <= '0;
      end else if (halt) begin
        state_q <= IDLE;
      end else if (run) begin
        keys_tried_q <= keys_tried_q + done_cnt;
        if (succ) begin
          state_q     <= FOUND;
          found_q     <= 1'b1;
          found_key_q <= slot_key[win_idx];
        end else if (!have_keys && slot_busy == '0) begin
          state_q     <= EXHAUSTED;
          exhausted_q <= 1'b1;
        end
      end
    end
  end

  assign core_start_o = core_start_q;
  assign core_abort_o = core_abort_q;
  assign busy_o       = state_q == RUN;
  assign found_o      = found_q;
  assign exhausted_o  = exhausted_q;
  assign found_key_o  = found_key_q;
  assign keys_tried_o = keys_tried_q;
endmodule
